// File: rtl/transpad_pkg.sv
// Shared types and helpers for the transpad memory port.
package transpad_pkg;

  localparam int unsigned TP_AW = 24;

  typedef enum logic [2:0] {
    IDLE,
    SPM_RD,
    SPM_CAP,
    MM_REQ,
    MM_WAIT,
    OUT
  } mport_state_t;

  // True when every address bit above the SPM word-address field is zero.
  function automatic logic spm_in_range(input logic [63:0] a, input int unsigned spm_aw);
    return (a >> spm_aw) == 64'd0;
  endfunction

endpackage

// File: rtl/transpad_mport_stats.sv
// Saturating per-class accept counters for transpad_mport (TRANSPAD_MPORT_STATS_EN builds only).
module transpad_mport_stats
  import transpad_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc_spm,
  input  logic        inc_mm,
  input  logic        inc_err,
  output logic [31:0] stat_spm,
  output logic [31:0] stat_mm,
  output logic [31:0] stat_err
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_spm <= '0;
      stat_mm  <= '0;
      stat_err <= '0;
    end else begin
      if (inc_spm && stat_spm != '1) stat_spm <= stat_spm + 32'd1;
      if (inc_mm  && stat_mm  != '1) stat_mm  <= stat_mm  + 32'd1;
      if (inc_err && stat_err != '1) stat_err <= stat_err + 32'd1;
    end
  end

endmodule

// File: rtl/transpad_mport.sv
// Memory-side responder for transpad: one SPM or main-memory read per address, result on valid/ready.
// Optional per-class accept counters via TRANSPAD_MPORT_STATS_EN.
module transpad_mport
  import transpad_pkg::*;
#(
  parameter int unsigned AW     = TP_AW,
  parameter int unsigned DW     = 32,
  parameter int unsigned SPM_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AW-1:0]     addr,
  input  logic              act,
  input  logic              spm,
  output logic              rdy,
  output logic              spm_en,
  output logic [SPM_AW-1:0] spm_addr,
  input  logic [DW-1:0]     spm_rdata,
  output logic              mm_req,
  output logic [AW-1:0]     mm_addr,
  input  logic              mm_gnt,
  input  logic              mm_rvalid,
  input  logic [DW-1:0]     mm_rdata,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              rd_err,
  input  logic              rd_ready
`ifdef TRANSPAD_MPORT_STATS_EN
  ,
  output logic [31:0]       stat_spm,
  output logic [31:0]       stat_mm,
  output logic [31:0]       stat_err
`endif
);

  mport_state_t  state, state_nx;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          err_q;
  logic          accept;
  logic          in_range;

  assign accept   = act & (state == IDLE);
  assign in_range = spm_in_range(64'(addr), SPM_AW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // The target class is resolved at accept and carried by the state, so spm needs no register.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (act) begin
          if (!spm)          state_nx = MM_REQ;
          else if (in_range) state_nx = SPM_RD;
          else               state_nx = OUT;
        end
      end
      SPM_RD:  state_nx = SPM_CAP;
      SPM_CAP: state_nx = OUT;
      MM_REQ:  if (mm_gnt)    state_nx = MM_WAIT;
      MM_WAIT: if (mm_rvalid) state_nx = OUT;
      OUT:     if (rd_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        err_q  <= spm & ~in_range;
        if (spm && !in_range) data_q <= '0;
      end
      if (state == SPM_CAP)                data_q <= spm_rdata;
      if (state == MM_WAIT && mm_rvalid)   data_q <= mm_rdata;
    end
  end

  assign rdy      = (state == IDLE);
  assign spm_en   = (state == SPM_RD);
  assign spm_addr = addr_q[SPM_AW-1:0];
  assign mm_req   = (state == MM_REQ);
  assign mm_addr  = addr_q;
  assign rd_valid = (state == OUT);
  assign rd_data  = data_q;
  assign rd_err   = err_q;

`ifdef TRANSPAD_MPORT_STATS_EN
  transpad_mport_stats u_stats (
    .clk      (clk),
    .rstn     (rstn),
    .inc_spm  (accept & spm & in_range),
    .inc_mm   (accept & ~spm),
    .inc_err  (accept & spm & ~in_range),
    .stat_spm (stat_spm),
    .stat_mm  (stat_mm),
    .stat_err (stat_err)
  );
`endif

endmodule
